// File: rtl/sev_seg_scan.sv
`timescale 1ns/1ps
// Four-digit multiplexed seven-segment scanner: a prescaler sets the slot length, each slot
// opens with a guard gap, and leading zero digits can be blanked.
module sev_seg_scan #(
    parameter int unsigned CLK_DIV = 50000,
    parameter int unsigned GUARD   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        blank_lz,
    output logic [3:0]  hex_digit,
    output logic [3:0]  digit_en,
    output logic        frame_tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   disp_q, disp_d;
    logic          blank_q, blank_d;
    logic          frame_tick_q, frame_tick_d;
    logic          slot_tick;
    logic          in_guard;
    logic          lz_blank;
    logic [3:0]    en_raw;

    always_comb begin
        slot_tick    = (cnt_q == CW'(CLK_DIV - 1));
        cnt_d        = slot_tick ? '0 : cnt_q + CW'(1);
        idx_d        = slot_tick ? idx_q + 2'd1 : idx_q;
        disp_d       = load ? value : disp_q;
        blank_d      = blank_lz;
        frame_tick_d = slot_tick && (idx_q == 2'd3);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            disp_q       <= 16'h0000;
            blank_q      <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            blank_q      <= blank_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // A zero-length guard would make the unsigned compare constant, so it is elided.
    generate
        if (GUARD == 0) begin : g_no_guard
            assign in_guard = 1'b0;
        end else begin : g_guard
            assign in_guard = (cnt_q < CW'(GUARD));
        end
    endgenerate

    always_comb begin
        hex_digit = disp_q[{idx_q, 2'b00} +: 4];
        // Blank when this digit and every more-significant digit is zero; digit 0 always shows.
        lz_blank  = blank_q && (idx_q != 2'd0) && ((disp_q >> {idx_q, 2'b00}) == 16'h0000);
        en_raw    = ~(4'b0001 << idx_q);
        if (in_guard || lz_blank) begin
            en_raw = 4'b1111;
        end
        // Keeps the digits dark during reset even when no guard interval exists.
        digit_en  = rst_n ? en_raw : 4'b1111;
    end

    assign frame_tick = frame_tick_q;

endmodule
